rr_mux4: RTL and testbench

- 4-to-1 round-robin merging multiplexer. It is the inverse of the existing 1-to-4 demux: four 16-bit producer channels are merged onto one registered output stream.
- Each output word carries its 2-bit source channel id on out_sel, encoded the same way as the demux select `s` (2'b00 = y0 ... 2'b11 = y3). A demux driven by out_sel/out_data therefore reconstructs the original channels.
- Sits between per-channel producers and a single shared downstream consumer, with valid/ready handshakes on both sides.

---
 rtl/rr_mux4.sv | 125 ++++++++++++
 tb/tb_rr_mux4.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// rr_mux4 - 4-to-1 round-robin merging multiplexer with a registered output.
//
// Four producer channels are merged onto one output stream. Each output word
// carries its source channel id on out_sel, using the same encoding as the
// 1-to-4 demux select, so the demux can split the stream back into channels.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    packed channel words, channel k at [k*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero, combinational
//   out_data   registered merged word
//   out_sel    registered source channel id of out_data
//   out_valid  registered, out_data/out_sel are meaningful
//   out_ready  downstream accepts the word this cycle
//
// Build option: define RR_MUX4_FIXED_PRIO_EN for fixed priority arbitration
// (channel 0 highest, channel 3 lowest) instead of round-robin.
//
// Output register states:
//   state | meaning
//   EMPTY | no word held, out_valid = 0
//   FULL  | word held on out_data/out_sel, out_valid = 1

module rr_mux4 #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_valid,
  output logic [3:0]          in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [1:0]          out_sel_q, out_sel_d;
  logic [1:0]          ptr_eff;
  logic                load_en;
  logic                grant_found;
  logic [1:0]          grant_idx;

`ifdef RR_MUX4_FIXED_PRIO_EN
  // Fixed priority is a round-robin search that always starts at channel 0.
  assign ptr_eff = 2'd0;
`else
  logic [1:0]          ptr_q, ptr_d;
  assign ptr_eff = ptr_q;
`endif

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign load_en   = !out_valid || out_ready;

  // Search ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap). Iterating from the
  // farthest offset down lets the nearest valid channel win.
  always_comb begin
    logic [1:0] idx;
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_eff + 2'(i);
      if (in_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Ready is suppressed during reset so no producer sees a handshake that
  // the reset will discard.
  always_comb begin
    in_ready = 4'b0000;
    if (grant_found && load_en && !rst)
      in_ready = 4'b0001 << grant_idx;
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
`ifndef RR_MUX4_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    if (load_en) begin
      if (grant_found) begin
        state_d    = FULL;
        out_data_d = in_data[grant_idx*DATA_W +: DATA_W];
        out_sel_d  = grant_idx;
`ifndef RR_MUX4_FIXED_PRIO_EN
        ptr_d      = grant_idx + 2'd1;
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_sel_q  <= 2'b00;
`ifndef RR_MUX4_FIXED_PRIO_EN
      ptr_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
`ifndef RR_MUX4_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
module tb_rr_mux4;

  localparam int DATA_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_valid;
  logic [3:0]          in_ready;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_valid;
  logic                out_ready;

  int n_cmp = 0;
  int n_err = 0;

  rr_mux4 #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] TBL_DATA = {16'hABCD, 16'h1011, 16'h322A, 16'h010C};

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_valid;
    logic [1:0]  e_sel;
    logic [15:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t r);
    in_valid  = r.v;
    out_ready = r.ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(r.e_rdy));
    @(posedge clk); #1;
    chk("out_valid", 64'(out_valid), 64'(r.e_valid));
    chk("out_sel", 64'(out_sel), 64'(r.e_sel));
    chk("out_data", 64'(out_data), 64'(r.e_data));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst in_ready", 64'(in_ready), 64'h0);
    end
    chk("rst out_valid", 64'(out_valid), 64'h0);
    chk("rst out_data", 64'(out_data), 64'h0);
    chk("rst out_sel", 64'(out_sel), 64'h0);
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  // Reference model state: held word and round-robin pointer.
  bit          m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_sel;
  int          m_ptr;

  initial begin
    rst = 1'b1;
    in_data = TBL_DATA;
    in_valid = 4'b0000;
    out_ready = 1'b0;

`ifdef RR_MUX4_FIXED_PRIO_EN
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    tbl.push_back('{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1110, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h1011});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h1011});
`else
    // round-robin with wrap
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h1011});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hABCD});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h322A});
    // backpressure 3 clks, then next grant ch2
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h1011});
    // move ptr to 1, then sparse 1001 skips to ch3, then ch0
    tbl.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    tbl.push_back('{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hABCD});
    tbl.push_back('{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h010C});
    // drain: out_valid falls, data/sel hold
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h010C});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h010C});
    // empty register loads even with out_ready low, then holds
    tbl.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h322A});
    tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h322A});
`endif

    do_reset();
    foreach (tbl[i]) apply(tbl[i]);

    // single channel with its own data word
    do_reset();
    in_data = {16'hABCD, 16'h432F, 16'h322A, 16'h010C};
    apply('{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h432F});

    // reset while holding a word under backpressure discards it
    apply('{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h432F});
    rst = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    chk("midrst out_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;
    apply('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h432F & 16'h0 | 16'h010C});

    // randomized run against the reference model
    do_reset();
    m_valid = 0; m_data = '0; m_sel = '0; m_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      logic [3:0] e_rdy;
      in_data   = {$urandom, $urandom};
      in_valid  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) in_valid = 4'b0000;
      out_ready = ($urandom_range(0, 3) != 0);
      g = -1;
      if (!m_valid || out_ready) begin
        for (int j = 0; j < 4; j++) begin
          int k;
`ifdef RR_MUX4_FIXED_PRIO_EN
          k = j;
`else
          k = (m_ptr + j) % 4;
`endif
          if (g < 0 && in_valid[k]) g = k;
        end
      end
      e_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      chk("rnd in_ready", 64'(in_ready), 64'(e_rdy));
      if (g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*16 +: 16];
        m_sel   = 2'(g);
        m_ptr   = (g + 1) % 4;
      end else if (!m_valid || out_ready) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
      chk("rnd out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd out_sel", 64'(out_sel), 64'(m_sel));
        chk("rnd out_data", 64'(out_data), 64'(m_data));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
